// File: rtl/csr_timer_if.sv
// CSR-side signal bundle for csr_timer: write strobes and data in; read data,
// timer interrupt level and expiry pulse out.
interface csr_timer_if;
  logic        csr_tcfg_wen;
  logic        csr_ticlr_wen;
  logic [31:0] csr_wdata;
  logic [31:0] csr_tcfg_rdata;
  logic [31:0] csr_tval_rdata;
  logic [31:0] csr_ticlr_rdata;
  logic        csr_timer_intr_sync;
  logic        timer_expire_pulse;

  modport master (
    output csr_tcfg_wen, csr_ticlr_wen, csr_wdata,
    input  csr_tcfg_rdata, csr_tval_rdata, csr_ticlr_rdata,
           csr_timer_intr_sync, timer_expire_pulse
  );

  modport slave (
    input  csr_tcfg_wen, csr_ticlr_wen, csr_wdata,
    output csr_tcfg_rdata, csr_tval_rdata, csr_ticlr_rdata,
           csr_timer_intr_sync, timer_expire_pulse
  );
endinterface

// File: rtl/csr_timer.sv
// Constant-timer CSR block (TCFG/TVAL/TICLR): down-counter with level TI and expiry pulse.
// Optional tick prescaler enabled by defining CSR_TIMER_PRESCALE_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | timer disabled, tval frozen, no expiry
// S_COUNT | counting down on each tick; expiry when tval==0 on a tick
// S_DONE  | one-shot finished, tval held at 0 until the next TCFG write
module csr_timer #(
  parameter int TIMER_W      = 32,
  parameter int PRESCALE_DIV = 4
) (
  input  logic        clk,
  input  logic        resetn,
  csr_timer_if.slave  bus
);

  if (TIMER_W < 3 || TIMER_W > 32 || PRESCALE_DIV < 2) begin : g_param_check
    $error("csr_timer: TIMER_W must be 3..32 and PRESCALE_DIV >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TIMER_W-1:0] r_tcfg;
  logic [TIMER_W-1:0] r_tval;
  logic [TIMER_W-1:0] w_tval_nxt;
  logic               r_ti;
  logic               r_pulse;
  logic               w_tick;
  logic               w_expire;
  logic [TIMER_W-1:0] w_reload;
  logic [TIMER_W-1:0] w_wr_reload;
  logic               w_tcfg_wr;
  logic               w_ticlr;

  assign w_tcfg_wr   = bus.csr_tcfg_wen;
  assign w_ticlr     = bus.csr_ticlr_wen & bus.csr_wdata[0];
  assign w_reload    = {r_tcfg[TIMER_W-1:2], 2'b00};
  assign w_wr_reload = {bus.csr_wdata[TIMER_W-1:2], 2'b00};

`ifdef CSR_TIMER_PRESCALE_EN
  localparam int PRE_W = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE_DIV - 1);

  logic [PRE_W-1:0] r_pre;

  // Prescaler only runs while counting so every fresh arm starts a full tick period.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pre <= '0;
    end else if (w_tcfg_wr || (r_state != S_COUNT) || (r_pre == PRE_MAX)) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  assign w_tick = (r_state == S_COUNT) && (r_pre == PRE_MAX);
`else
  assign w_tick = (r_state == S_COUNT);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_tval  <= '0;
      r_tcfg  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tval  <= w_tval_nxt;
      if (w_tcfg_wr) begin
        r_tcfg <= bus.csr_wdata[TIMER_W-1:0];
      end
    end
  end

  // A TCFG write overrides any expiry landing in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_tval_nxt  = r_tval;
    w_expire    = 1'b0;
    if (w_tcfg_wr) begin
      w_state_nxt = bus.csr_wdata[0] ? S_COUNT : S_IDLE;
      w_tval_nxt  = w_wr_reload;
    end else if (w_tick) begin
      if (r_tval != '0) begin
        w_tval_nxt = r_tval - TIMER_W'(1);
      end else begin
        w_expire = 1'b1;
        if (r_tcfg[1]) begin
          w_tval_nxt = w_reload;
        end else begin
          w_tval_nxt  = '0;
          w_state_nxt = S_DONE;
        end
      end
    end
  end

  // Set has priority over clear so a racing TICLR cannot swallow an interrupt.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ti    <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_expire & ~r_ti;
      if (w_expire) begin
        r_ti <= 1'b1;
      end else if (w_ticlr) begin
        r_ti <= 1'b0;
      end
    end
  end

  assign bus.csr_tcfg_rdata      = 32'(r_tcfg);
  assign bus.csr_tval_rdata      = 32'(r_tval);
  assign bus.csr_ticlr_rdata     = 32'd0;
  assign bus.csr_timer_intr_sync = r_ti;
  assign bus.timer_expire_pulse  = r_pulse;

endmodule
